uart_rx_fifo: RTL and testbench

Parametrised UART receiver, next generation of the protocols-library UART RX. It adds configurable data width, runtime parity and stop-bit modes, per-word error flags, and an output FIFO with a valid/ready handshake. It sits between an asynchronous serial pin and any stream consumer in the design.

---
 rtl/uart_rx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime parity/stop configuration, per-word error flags and an output FIFO.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote around each bit centre (one cycle more latency).
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BIT_TIME_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic [BIT_TIME_W-1:0] bit_time,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BITS-1:0]  out_data,
    output logic                  out_parity_err,
    output logic                  out_frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BCW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

    state_e                state_q;
    logic                  rx_s1_q, rx_s2_q, rx_d_q;
    logic [BIT_TIME_W-1:0] cnt_q, bt_q, dec_cnt, cnt_d;
    logic [1:0]            pm_q;
    logic                  two_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic [BCW-1:0]        bitn_q;
    logic                  perr_q, ferr_q;
    logic                  fall, bit_val, dec_now, parity_en, par_bad, push, push_ferr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_d_q  <= rx_s2_q;
        end
    end

    assign fall = rx_d_q & ~rx_s2_q;

`ifdef UART_RX_MAJORITY_EN
    // hist_q holds the samples from C-1 and C; the vote completes with the live sample at C+1.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist_q <= '1;
        else      hist_q <= {hist_q[0], rx_s2_q};
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s2_q) | (hist_q[0] & rx_s2_q);
    assign dec_cnt = (bt_q >> 1) + BIT_TIME_W'(1);
`else
    assign bit_val = rx_s2_q;
    assign dec_cnt = bt_q >> 1;
`endif

    assign cnt_d     = (cnt_q == bt_q - BIT_TIME_W'(1)) ? '0 : cnt_q + BIT_TIME_W'(1);
    assign dec_now   = (state_q != IDLE) && (cnt_q == dec_cnt);
    assign parity_en = (pm_q == 2'b01) || (pm_q == 2'b10);
    assign par_bad   = (pm_q == 2'b01) ? (^shift_q ^ bit_val) : ~(^shift_q ^ bit_val);
    assign push      = dec_now && (((state_q == STOP1) && !two_q) || (state_q == STOP2));
    assign push_ferr = ferr_q | ~bit_val;
    assign busy      = (state_q != IDLE);

    // Counter value in cycle E+k is k mod bit_time, so every bit centre sits at bit_time/2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bt_q    <= '0;
            pm_q    <= '0;
            two_q   <= 1'b0;
            shift_q <= '0;
            bitn_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (state_q != IDLE) cnt_q <= cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= START;
                        cnt_q   <= BIT_TIME_W'(1);
                        bt_q    <= bit_time;
                        pm_q    <= parity_mode;
                        two_q   <= two_stop;
                        bitn_q  <= '0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                START: begin
                    if (dec_now) state_q <= bit_val ? IDLE : DATA;
                end
                DATA: begin
                    if (dec_now) begin
                        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        bitn_q  <= bitn_q + BCW'(1);
                        if (bitn_q == BCW'(DATA_BITS - 1))
                            state_q <= parity_en ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (dec_now) begin
                        perr_q  <= par_bad;
                        state_q <= STOP1;
                    end
                end
                STOP1: begin
                    if (dec_now) begin
                        ferr_q  <= ~bit_val;
                        state_q <= two_q ? STOP2 : IDLE;
                    end
                end
                STOP2: begin
                    if (dec_now) begin
                        ferr_q  <= push_ferr;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [DATA_BITS+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        fcnt_q;
    logic                 ovr_q, full, pop, wr;

    assign full = (fcnt_q == CW'(FIFO_DEPTH));
    assign pop  = out_valid & out_ready;
    assign wr   = push & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= push & full & ~pop;
            if (wr) begin
                mem_q[wptr_q] <= {shift_q, perr_q, push_ferr};
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
            fcnt_q <= fcnt_q + CW'(wr) - CW'(pop);
        end
    end

    assign out_valid = (fcnt_q != '0);
    assign {out_data, out_parity_err, out_frame_err} = mem_q[rptr_q];
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vectors, corner sequences and a randomized scoreboard.
module tb_uart_rx_fifo;

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned MAJ = 1;
`else
    localparam int unsigned MAJ = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, rx, two_stop, out_ready;
    logic [15:0] bit_time;
    logic [1:0]  parity_mode;
    logic        out_valid, out_parity_err, out_frame_err, overrun, busy;
    logic [7:0]  out_data;

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .BIT_TIME_W(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .bit_time(bit_time), .parity_mode(parity_mode),
        .two_stop(two_stop), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity_err(out_parity_err), .out_frame_err(out_frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_chk = 0, n_pass = 0;
    logic [9:0]  got[$];
    logic [9:0]  exp_q[$];
    int unsigned vh_cnt = 0, ovr_cnt = 0, rise_cyc = 0, ovr_cyc = 0, last_c0 = 0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got.push_back({out_data, out_parity_err, out_frame_err});
        if (out_valid) vh_cnt++;
        if (out_valid && !prev_valid) rise_cyc = cyc;
        if (overrun) begin ovr_cnt++; ovr_cyc = cyc; end
        prev_valid = out_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sample_at(input int unsigned n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int unsigned bt);
        rx = b;
        repeat (bt) @(posedge clk);
        #1;
    endtask

    // Control inputs are scrambled once the start bit is out: the DUT must use its latched copies.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                              input logic two, input logic s1, input logic s2, input int unsigned bt);
        bit_time = 16'(bt); parity_mode = pm; two_stop = two;
        @(posedge clk); #1;
        last_c0 = cyc;
        send_bit(1'b0, bt);
        bit_time = 16'($urandom_range(8, 60));
        parity_mode = 2'($urandom);
        two_stop = 1'($urandom);
        for (int i = 0; i < 8; i++) send_bit(d[i], bt);
        if (pm == 2'b01 || pm == 2'b10) send_bit(pb, bt);
        send_bit(s1, bt);
        if (two) send_bit(s2, bt);
        if (!(two ? s2 : s1)) send_bit(1'b1, bt);
    endtask

    task automatic wait_words(input string name, input int unsigned n);
        int unsigned k = 0;
        while (got.size() < n && k < 6000) begin @(negedge clk); k++; end
        chk(name, 32'(got.size() >= n), 32'd1);
    endtask

    function automatic logic [9:0] model_word(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                                              input logic two, input logic s1, input logic s2);
        int unsigned ones = $countones(d) + 32'(pb);
        logic pe = (pm == 2'b01) ? (ones % 2 != 0) : (pm == 2'b10) ? (ones % 2 == 0) : 1'b0;
        logic fe = !s1 || (two && !s2);
        return {d, pe, fe};
    endfunction

    typedef struct {
        logic [7:0] d; logic [1:0] pm; logic pb, two, s1, s2;
        logic [7:0] ed; logic ep, ef;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int unsigned c0;
        logic [7:0]  d;
        logic        rnd_done;

        vecs[0]  = '{8'hCA, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCA, 1'b0, 1'b0};
        vecs[1]  = '{8'hCA, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hCA, 1'b1, 1'b0};
        vecs[2]  = '{8'hCA, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCA, 1'b0, 1'b0};
        vecs[3]  = '{8'hCA, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hCA, 1'b0, 1'b0};
        vecs[4]  = '{8'hCA, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCA, 1'b1, 1'b0};
        vecs[5]  = '{8'hCA, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hCA, 1'b0, 1'b1};
        vecs[6]  = '{8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[7]  = '{8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[8]  = '{8'h3C, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[9]  = '{8'h81, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[10] = '{8'hFF, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[11] = '{8'h00, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b0; rx = 1'b1; out_ready = 1'b0;
        bit_time = 16'd16; parity_mode = 2'd0; two_stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({out_valid, out_data, out_parity_err, out_frame_err, overrun, busy}), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Single byte: one valid pulse at D_9+1.
        out_ready = 1'b1; got.delete(); vh_cnt = 0;
        send_frame(8'hCA, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        c0 = last_c0;
        wait_words("t1_wait", 1);
        chk("t1_word", 32'(got[0]), 32'({8'hCA, 2'b00}));
        chk("t1_valid_cycle", rise_cyc, c0 + 2 + 8 + 9 * 16 + MAJ + 1);
        repeat (20) @(posedge clk); #1;
        chk("t1_valid_pulses", vh_cnt, 32'd1);

        for (int i = 0; i < 12; i++) begin
            got.delete();
            send_frame(vecs[i].d, vecs[i].pm, vecs[i].pb, vecs[i].two, vecs[i].s1, vecs[i].s2, 16);
            wait_words($sformatf("vec%0d_wait", i), 1);
            chk($sformatf("vec%0d_word", i), 32'(got[0]), 32'({vecs[i].ed, vecs[i].ep, vecs[i].ef}));
        end
        repeat (40) @(posedge clk); #1;

        // False start: 3-cycle low pulse.
        got.delete(); bit_time = 16'd16; parity_mode = 2'd0; two_stop = 1'b0;
        @(posedge clk); #1;
        c0 = cyc; rx = 1'b0;
        sample_at(c0 + 2);
        chk("fs_busy_before", 32'(busy), 32'd0);
        @(posedge clk); #1 rx = 1'b1;
        sample_at(c0 + 3);
        chk("fs_busy_rise", 32'(busy), 32'd1);
        sample_at(c0 + 10 + MAJ);
        chk("fs_busy_at_dec", 32'(busy), 32'd1);
        sample_at(c0 + 11 + MAJ);
        chk("fs_busy_fall", 32'(busy), 32'd0);
        repeat (200) @(negedge clk);
        chk("fs_no_word", got.size(), 32'd0);

        // Break: line low for 20 bit times, then high.
        got.delete();
        @(posedge clk); #1;
        send_bit(1'b0, 20 * 16);
        send_bit(1'b1, 2 * 16);
        wait_words("brk_wait", 1);
        repeat (40) @(negedge clk);
        chk("brk_count", got.size(), 32'd1);
        chk("brk_word", 32'(got[0]), 32'({8'h00, 2'b01}));

        // Back-to-back into a stalled FIFO.
        got.delete(); out_ready = 1'b0; ovr_cnt = 0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        repeat (10) @(negedge clk);
        chk("ovr_pulses", ovr_cnt, 32'd1);
        chk("ovr_cycle", ovr_cyc, last_c0 + 2 + 8 + 9 * 16 + MAJ + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_head", 32'({out_valid, out_data}), 32'({1'b1, 8'h01}));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_words("drain_wait", 4);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("drain%0d", i), 32'(got[i]), 32'({8'(i + 1), 2'b00}));
        chk("drain_empty", 32'({out_valid, 32'(got.size())}), 32'd4);

`ifdef UART_RX_MAJORITY_EN
        // Single-cycle inverted glitch at the centre of data bit 3.
        got.delete(); d = 8'hCA; bit_time = 16'd16; parity_mode = 2'd0; two_stop = 1'b0;
        @(posedge clk); #1;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rx = d[i]; repeat (8) @(posedge clk);
                #1 rx = ~d[i]; @(posedge clk);
                #1 rx = d[i]; repeat (7) @(posedge clk); #1;
            end else send_bit(d[i], 16);
        end
        send_bit(1'b1, 16);
        wait_words("glitch_wait", 1);
        chk("glitch_word", 32'(got[0]), 32'({8'hCA, 2'b00}));
`endif

        // Reset during data bit 4 with a word already queued.
        got.delete(); out_ready = 1'b0; d = 8'hCA;
        send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        bit_time = 16'd16; parity_mode = 2'd0; two_stop = 1'b0;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(d[i], 16);
        rx = d[4];
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_outputs", 32'({out_valid, out_data, out_parity_err, out_frame_err, overrun, busy}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        @(negedge clk);
        chk("rst_outputs_held", 32'({out_valid, out_data, out_parity_err, out_frame_err, overrun, busy}), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_fifo_empty", 32'({out_valid, busy}), 32'd0);
        out_ready = 1'b1;
        send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16);
        wait_words("rst_next_wait", 1);
        chk("rst_next_word", 32'(got[0]), 32'({8'hA5, 2'b00}));

        // Randomized frames against the model with a randomly stalling consumer.
        got.delete(); exp_q.delete(); ovr_cnt = 0; rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    logic [7:0] rd; logic [1:0] rpm; logic rpb, rtwo, rs1, rs2;
                    rd = 8'($urandom); rpm = 2'($urandom); rpb = 1'($urandom); rtwo = 1'($urandom);
                    rs1 = ($urandom_range(0, 5) != 0); rs2 = ($urandom_range(0, 5) != 0);
                    exp_q.push_back(model_word(rd, rpm, rpb, rtwo, rs1, rs2));
                    send_frame(rd, rpm, rpb, rtwo, rs1, rs2, $urandom_range(8, 24));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1 out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        wait_words("rnd_wait", 25);
        for (int i = 0; i < 25 && i < got.size(); i++)
            chk($sformatf("rnd%0d", i), 32'(got[i]), 32'(exp_q[i]));
        chk("rnd_no_overrun", ovr_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
